// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Requests are valid/ready; responses return in order, one per accepted request.
interface if_fetch_unit_if;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INST_W = 32;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// RV64 instruction fetch stage: owns the PC, issues in-order imem requests, buffers
// responses in a small prefetch queue and presents {PC, inst} (or a bubble) to IF/ID.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PC_Write,
    input  logic                   branch_taken,
    input  logic [63:0]            branch_target,
    if_fetch_unit_if.master        imem,
    output logic [63:0]            PC_Out,
    output logic [31:0]            Inst_Out,
    output logic                   inst_valid
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    // Architectural / queue state
    logic [XLEN-1:0]  fetch_pc_q,    fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q,     resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q,    drop_cnt_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    entry_t           queue_q [DEPTH];

    logic             space_ok;
    logic             accept;
    logic             dropping;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  target_aligned;
    entry_t           head;
    logic             unused_target_bits;

    assign unused_target_bits = ^branch_target[1:0];
    assign target_aligned     = {branch_target[XLEN-1:2], 2'b00};

    // Request side and handshake qualifiers. Space check ignores a same-cycle pop.
    always_comb begin
        space_ok       = (SUM_W'(outstanding_q) + SUM_W'(count_q)) < SUM_W'(DEPTH);
        imem.imem_req  = !reset && !branch_taken && space_ok;
        imem.imem_addr = fetch_pc_q;
        accept         = imem.imem_req && imem.imem_ready;
        dropping       = (drop_cnt_q != '0);
        push           = imem.imem_rvalid && !dropping && !branch_taken;
        inst_valid     = (count_q != '0);
        pop            = PC_Write && inst_valid && !branch_taken;
    end

    // Presented head; a bubble is all zeros.
    always_comb begin
        head     = queue_q[rd_ptr_q];
        PC_Out   = inst_valid ? head.pc   : '0;
        Inst_Out = inst_valid ? head.inst : '0;
    end

    // Next-state logic; a redirect flushes the queue and retargets both PCs.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem.imem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (branch_taken) begin
            fetch_pc_d = target_aligned;
            resp_pc_d  = target_aligned;
            // Every response still in flight is stale; drop_cnt is a subset of outstanding.
            drop_cnt_d = outstanding_q - CNT_W'(imem.imem_rvalid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem.imem_rvalid && dropping) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage; contents are only observed through count, so no reset needed.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            queue_q[wr_ptr_q] <= '{pc: resp_pc_q, inst: imem.imem_rdata};
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order variable-latency memory plus a queue-based
// reference model of the fetch stage; directed scenarios followed by random traffic.
module tb_if_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PC_Write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic [63:0] PC_Out;
    logic [31:0] Inst_Out;
    logic        inst_valid;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .PC_Write      (PC_Write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus),
        .PC_Out        (PC_Out),
        .Inst_Out      (Inst_Out),
        .inst_valid    (inst_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; bit stale; } flight_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [63:0] addr; int due; } mreq_t;

    flight_t     inflight[$];
    ent_t        fifo[$];
    mreq_t       mpend[$];
    logic [63:0] m_fetch = RST_PC;
    int          mem_lat = 0;
    int          cyc = 0;
    bit          checking = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit pcw, input bit br,
                         input logic [63:0] tgt, input bit rdy);
        bit      exp_req;
        bit      same_cycle;
        bit      rv;
        bit      do_pop;
        flight_t r;
        reset            = rst;
        PC_Write         = pcw;
        branch_taken     = br;
        branch_target    = tgt;
        bus.imem_ready   = rdy;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = '0;
        same_cycle       = 0;
        #1;
        // Memory: oldest due response first; zero-latency answers in the request cycle
        if (!rst) begin
            if (mpend.size() > 0 && mpend[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(mpend[0].addr);
            end else if (mpend.size() == 0 && mem_lat == 0 && bus.imem_req && rdy) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(bus.imem_addr);
                same_cycle      = 1;
            end
        end
        #1;
        exp_req = !rst && !br && (inflight.size() + fifo.size() < DEPTH);
        if (checking) begin
            chk("imem_req", 64'(bus.imem_req), 64'(exp_req));
            if (exp_req) chk("imem_addr", bus.imem_addr, m_fetch);
            chk("inst_valid", 64'(inst_valid), 64'(fifo.size() != 0));
            chk("Inst_Out", 64'(Inst_Out), (fifo.size() != 0) ? 64'(fifo[0].inst) : 64'd0);
            chk("PC_Out", PC_Out, (fifo.size() != 0) ? fifo[0].pc : 64'd0);
        end
        rv = bus.imem_rvalid;
        if (rst) begin
            mpend.delete();
        end else begin
            if (rv && !same_cycle) void'(mpend.pop_front());
            if (bus.imem_req && rdy && !same_cycle)
                mpend.push_back('{addr: bus.imem_addr, due: cyc + mem_lat});
        end
        // Reference model: requests in flight tagged stale on redirect, FIFO of kept words
        if (rst) begin
            inflight.delete();
            fifo.delete();
            m_fetch = RST_PC;
        end else begin
            do_pop = pcw && (fifo.size() != 0) && !br;
            if (exp_req && rdy) begin
                inflight.push_back('{addr: m_fetch, stale: 0});
                m_fetch = m_fetch + 64'd4;
            end
            if (do_pop) void'(fifo.pop_front());
            if (rv) begin
                if (checking) chk("resp_expected", 64'(inflight.size() > 0), 64'd1);
                if (inflight.size() > 0) begin
                    r = inflight.pop_front();
                    if (!r.stale && !br) fifo.push_back('{pc: r.addr, inst: mem_word(r.addr)});
                end
            end
            if (br) begin
                foreach (inflight[i]) inflight[i].stale = 1;
                fifo.delete();
                m_fetch = {tgt[63:2], 2'b00};
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] tgt;
        // Reset
        cycle(1, 1, 0, '0, 1);
        checking = 1;
        cycle(1, 1, 0, '0, 1);
        // Single-cycle memory, free-running fetch
        mem_lat = 0;
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, '0, 1);
        // Stall: queue fills, head held, then resumes without gap
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0, 1);
        // 3-cycle memory with two outstanding, redirect to 0x2003
        mem_lat = 3;
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, 1);
        cycle(0, 1, 1, 64'h2003, 1);
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, '0, 1);
        // Redirect coinciding with a response and a pop
        mem_lat = 1;
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, '0, 1);
        cycle(0, 1, 1, 64'h3000, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, '0, 1);
        // Memory not ready: address stable, queue drains
        mem_lat = 0;
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0, 1);
        // PC wrap at the top of the address space
        cycle(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF9, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, 1);
        // Reset with two responses outstanding
        mem_lat = 3;
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0, 1);
        cycle(1, 1, 0, '0, 1);
        mem_lat = 0;
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, 1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) mem_lat = int'($urandom_range(0, 4));
            tgt = {$urandom(), $urandom()};
            if ($urandom_range(0, 9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  tgt,
                  $urandom_range(0, 4) != 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
